// File: rtl/pic_pkg.sv
// pic_pkg: shared flag codes, readback codes and sequencer state encoding for the 8259 bus side
package pic_pkg;
    localparam logic [2:0] CW_ICW1 = 3'd0;
    localparam logic [2:0] CW_ICW2 = 3'd1;
    localparam logic [2:0] CW_ICW3 = 3'd2;
    localparam logic [2:0] CW_ICW4 = 3'd3;
    localparam logic [2:0] CW_OCW1 = 3'd4;
    localparam logic [2:0] CW_OCW2 = 3'd5;
    localparam logic [2:0] CW_OCW3 = 3'd6;
    localparam logic [2:0] CW_NONE = 3'd7;

    localparam logic [2:0] RD_IDLE = 3'b000;
    localparam logic [2:0] RD_IMR  = 3'b011;
    localparam logic [2:0] RD_IRR  = 3'b001;
    localparam logic [2:0] RD_ISR  = 3'b101;
    localparam logic [2:0] RD_POLL = 3'b111;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_ICW2 = 3'd1;
    localparam logic [2:0] ST_WAIT_ICW3 = 3'd2;
    localparam logic [2:0] ST_WAIT_ICW4 = 3'd3;
    localparam logic [2:0] ST_READY     = 3'd4;
endpackage

// File: rtl/pic_cmd_sequencer_if.sv
// pic_cmd_sequencer_if: CPU-side strobes, address bit and data bus of the 8259
interface pic_cmd_sequencer_if;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] data_in;
    modport master (output cs_n, wr_n, rd_n, a0, data_in);
    modport slave  (input  cs_n, wr_n, rd_n, a0, data_in);
endinterface

// File: rtl/pic_strobe_sync.sv
// pic_strobe_sync: multi-flop synchroniser for an active-low strobe with a rising-edge pulse
module pic_strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise
);
    logic [STAGES-1:0] sr;
    logic              prev;
    // Reset to the inactive (high) level so releasing reset never fakes an edge
    always_ff @(posedge clk)
        if (reset) begin
            sr   <= '1;
            prev <= 1'b1;
        end else begin
            sr   <= {sr[STAGES-2:0], d};
            prev <= sr[STAGES-1];
        end
    assign q    = sr[STAGES-1];
    assign rise = q & ~prev;
endmodule

// File: rtl/pic_cmd_sequencer.sv
// pic_cmd_sequencer: tracks the ICW1..ICW4 init sequence and OCW decode, emits one-cycle
// command flags with the latched byte, and owns the OCW3 readback/poll selection.
module pic_cmd_sequencer
    import pic_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] FLAG_NONE   = CW_NONE
) (
    input  logic               clk,
    input  logic               reset,
    pic_cmd_sequencer_if.slave bus,
    output logic [2:0]         cw_flag,
    output logic               cw_strobe,
    output logic [7:0]         cw_data,
    output logic               init_done,
    output logic               cw_err,
    output logic [2:0]         read_code,
    output logic               poll_pending
);
    logic       wr_s, wr_rise, rd_s, rd_rise, cs_s, cs_rise;
    logic       wr_ok, rd_ok, cap_a0, sngl, ic4, err, commit, icw1, reading;
    logic [7:0] cap_d;
    logic [2:0] state, nxt, flag, read_sel;

    pic_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr (.clk(clk), .reset(reset), .d(bus.wr_n), .q(wr_s), .rise(wr_rise));
    pic_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd (.clk(clk), .reset(reset), .d(bus.rd_n), .q(rd_s), .rise(rd_rise));
    pic_strobe_sync #(.STAGES(SYNC_STAGES)) u_cs (.clk(clk), .reset(reset), .d(bus.cs_n), .q(cs_s), .rise(cs_rise));

    assign commit    = wr_rise & wr_ok;
    assign icw1      = ~cap_a0 & cap_d[4];
    assign reading   = ~rd_s & ~cs_s & wr_s;
    assign init_done = state == ST_READY;

    // a0=0 with d[4]=1 is always ICW1, so READY only ever sees d[4:3] of 00 or 01 on a0=0
    always_comb begin
        flag = FLAG_NONE;
        nxt  = state;
        err  = 1'b0;
        if (icw1) begin
            flag = CW_ICW1;
            nxt  = ST_WAIT_ICW2;
        end else if (state == ST_READY)
            flag = cap_a0 ? CW_OCW1 : cap_d[3] ? CW_OCW3 : CW_OCW2;
        else if (cap_a0 && state != ST_IDLE) begin
            flag = state == ST_WAIT_ICW2 ? CW_ICW2 : state == ST_WAIT_ICW3 ? CW_ICW3 : CW_ICW4;
            nxt  = state == ST_WAIT_ICW2 && !sngl ? ST_WAIT_ICW3 :
                   state != ST_WAIT_ICW4 && ic4   ? ST_WAIT_ICW4 : ST_READY;
        end else
            err = 1'b1;
    end

    always_ff @(posedge clk)
        if (reset) begin
            state        <= ST_IDLE;
            cw_flag      <= FLAG_NONE;
            cw_strobe    <= 1'b0;
            cw_data      <= 8'h00;
            cw_err       <= 1'b0;
            read_code    <= RD_IDLE;
            poll_pending <= 1'b0;
            read_sel     <= RD_IRR;
            sngl         <= 1'b0;
            ic4          <= 1'b0;
            wr_ok        <= 1'b0;
            rd_ok        <= 1'b0;
            cap_a0       <= 1'b0;
            cap_d        <= 8'h00;
        end else begin
            if (!wr_s && !cs_s) begin
                wr_ok  <= 1'b1;
                cap_a0 <= bus.a0;
                cap_d  <= bus.data_in;
            end else if (wr_rise || cs_rise)
                wr_ok <= 1'b0;
            if (reading)
                rd_ok <= 1'b1;
            else if (rd_rise || cs_rise || !wr_s)
                rd_ok <= 1'b0;
            read_code <= reading ? (poll_pending ? RD_POLL : bus.a0 ? RD_IMR : read_sel) : RD_IDLE;
            cw_strobe <= commit && !err;
            cw_err    <= commit && err;
            cw_flag   <= commit ? flag : FLAG_NONE;
            if (rd_rise && rd_ok)
                poll_pending <= 1'b0;
            // A command in the same cycle as a completed read takes precedence on poll_pending
            if (commit && !err) begin
                state   <= nxt;
                cw_data <= cap_d;
                if (icw1) begin
                    sngl         <= cap_d[1];
                    ic4          <= cap_d[0];
                    read_sel     <= RD_IRR;
                    poll_pending <= 1'b0;
                end else if (flag == CW_OCW3) begin
                    if (cap_d[1])
                        read_sel <= cap_d[0] ? RD_ISR : RD_IRR;
                    if (cap_d[2])
                        poll_pending <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// tb_pic_cmd_sequencer: directed ICW/OCW sequences with hand-computed flags, readback codes and errors
`timescale 1ns/1ps
module tb_pic_cmd_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] cw_flag, read_code, s_flag, code;
    logic [7:0] cw_data, s_data;
    logic       cw_strobe, init_done, cw_err, poll_pending;
    int         n_chk = 0, n_pass = 0, s_strobes, s_errs;

    pic_cmd_sequencer_if bus ();

    pic_cmd_sequencer #(.SYNC_STAGES(2), .FLAG_NONE(3'b111)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .cw_flag(cw_flag), .cw_strobe(cw_strobe), .cw_data(cw_data), .init_done(init_done),
        .cw_err(cw_err), .read_code(read_code), .poll_pending(poll_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Watches a bounded window for strobes/errors after a write commit
    task automatic watch();
        s_strobes = 0;
        s_errs    = 0;
        s_flag    = 3'b111;
        s_data    = 8'h00;
        repeat (8) begin
            @(negedge clk);
            if (cw_strobe) begin
                s_strobes++;
                s_flag = cw_flag;
                s_data = cw_data;
            end
            if (cw_err) s_errs++;
        end
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        bus.cs_n = 1'b0; bus.a0 = a; bus.data_in = d; bus.wr_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.wr_n = 1'b1;
        watch();
        bus.cs_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_chk(input string tag, input logic a, input logic [7:0] d, input logic [2:0] f);
        wr(a, d);
        check({tag, "_cnt"}, s_strobes, 1);
        check({tag, "_flag"}, s_flag, f);
        check({tag, "_data"}, s_data, d);
        check({tag, "_err"}, s_errs, 0);
    endtask

    task automatic wr_err(input string tag, input logic a, input logic [7:0] d);
        wr(a, d);
        check({tag, "_cnt"}, s_strobes, 0);
        check({tag, "_err"}, s_errs, 1);
    endtask

    task automatic rd(input logic a, output logic [2:0] c);
        bus.cs_n = 1'b0; bus.a0 = a; bus.rd_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        c = read_code;
        bus.rd_n = 1'b1;
        repeat (4) @(posedge clk);
        bus.cs_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.a0 = 1'b0; bus.data_in = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("rst_flag", cw_flag, 3'b111);
        check("rst_strobe", cw_strobe, 0);
        check("rst_data", cw_data, 8'h00);
        check("rst_init", init_done, 0);
        check("rst_err", cw_err, 0);
        check("rst_rcode", read_code, 3'b000);
        check("rst_poll", poll_pending, 0);

        // single, no ICW4: ICW3 skipped
        wr_chk("t1_icw1", 1'b0, 8'h12, 3'd0);
        check("t1_init0", init_done, 0);
        check("t1_idle_flag", cw_flag, 3'b111);
        wr_chk("t1_icw2", 1'b1, 8'h20, 3'd1);
        check("t1_init1", init_done, 1);

        // cascade with ICW4
        wr_chk("t2_icw1", 1'b0, 8'h11, 3'd0);
        wr_chk("t2_icw2", 1'b1, 8'h08, 3'd1);
        check("t2_init_a", init_done, 0);
        wr_chk("t2_icw3", 1'b1, 8'h04, 3'd2);
        check("t2_init_b", init_done, 0);
        wr_chk("t2_icw4", 1'b1, 8'h01, 3'd3);
        check("t2_init_c", init_done, 1);

        // OCWs and readback select
        wr_chk("t3_ocw1", 1'b1, 8'hFB, 3'd4);
        wr_chk("t3_ocw2", 1'b0, 8'h20, 3'd5);
        wr_chk("t3_ocw3", 1'b0, 8'h0B, 3'd6);
        check("t3_hold_data", cw_data, 8'h0B);
        rd(1'b0, code);
        check("t3_rd_isr", code, 3'b101);
        rd(1'b1, code);
        check("t3_rd_imr", code, 3'b011);
        check("t3_rd_idle", read_code, 3'b000);

        // poll, with read_sel back to IRR in the same OCW3
        wr_chk("t4_ocw3", 1'b0, 8'h0E, 3'd6);
        check("t4_poll1", poll_pending, 1);
        rd(1'b0, code);
        check("t4_rd_poll", code, 3'b111);
        check("t4_poll0", poll_pending, 0);
        rd(1'b0, code);
        check("t4_rd_irr", code, 3'b001);

        // cs_n rises while wr_n low: aborted write
        bus.cs_n = 1'b0; bus.a0 = 1'b1; bus.data_in = 8'h55; bus.wr_n = 1'b0;
        repeat (4) @(posedge clk);
        bus.cs_n = 1'b1;
        repeat (4) @(posedge clk);
        bus.wr_n = 1'b1;
        watch();
        check("ab_cnt", s_strobes, 0);
        check("ab_err", s_errs, 0);
        check("ab_data", cw_data, 8'h0E);

        // ICW1 in READY restarts and drops poll
        wr_chk("t6_ocw3", 1'b0, 8'h0F, 3'd6);
        check("t6_poll1", poll_pending, 1);
        wr_chk("t6_icw1", 1'b0, 8'h10, 3'd0);
        check("t6_init0", init_done, 0);
        check("t6_poll0", poll_pending, 0);
        wr_chk("t6_icw2", 1'b1, 8'h00, 3'd1);
        check("t6_init_w3", init_done, 0);

        // reset during WAIT_ICW3 with a write in flight
        bus.cs_n = 1'b0; bus.a0 = 1'b1; bus.data_in = 8'h04; bus.wr_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("rs_flag", cw_flag, 3'b111);
        check("rs_data", cw_data, 8'h00);
        check("rs_init", init_done, 0);
        check("rs_rcode", read_code, 3'b000);
        bus.wr_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        watch();
        check("rs_cnt", s_strobes, 0);
        check("rs_err", s_errs, 0);
        bus.cs_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // errors: IDLE rejects non-ICW1, WAIT_ICW2 rejects a0=0 and holds state
        wr_err("t5_idle", 1'b1, 8'hFF);
        check("t5_init_idle", init_done, 0);
        wr_chk("t5_icw1", 1'b0, 8'h13, 3'd0);
        wr_err("t5_w2", 1'b0, 8'h20);
        wr_chk("t5_icw2", 1'b1, 8'h20, 3'd1);
        check("t5_init_w4", init_done, 0);
        wr_chk("t5_icw4", 1'b1, 8'h01, 3'd3);
        check("t5_init1", init_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
